// File: rtl/wb_dsp_sample_fetch.sv
// Wishbone read-DMA front end for the DSP datapath: fetches a block of
// 32-bit samples with classic single reads, buffers them in a small
// show-ahead FIFO and hands them to the algorithm core on a valid/ready
// stream. Completion and bus errors are reported to the control registers.
module wb_dsp_sample_fetch #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             wb_clk,
    input  logic             wb_rst,

    input  logic             start_i,
    input  logic [AW-1:0]    base_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,

    output logic [DW-1:0]    sample_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i,

    output logic [AW-1:0]    wb_master_adr_o,
    output logic [DW-1:0]    wb_master_dat_o,
    output logic [3:0]       wb_master_sel_o,
    output logic             wb_master_we_o,
    output logic             wb_master_cyc_o,
    output logic             wb_master_stb_o,
    output logic [2:0]       wb_master_cti_o,
    output logic [1:0]       wb_master_bte_o,
    input  logic [DW-1:0]    wb_master_dat_i,
    input  logic             wb_master_ack_i,
    input  logic             wb_master_err_i,
    input  logic             wb_master_rty_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT_SPACE,
        DRAIN
    } state_t;

    state_t           state;
    logic [AW-1:0]    adr_q;
    logic [LEN_W-1:0] remaining;
    logic             busy_q;
    logic             cyc_q;
    logic             done_q;
    logic             err_q;

    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_push;
    logic             push;
    logic             pop;

    // An error response wins over a simultaneous ack, so its data is never buffered.
    assign push = (state == READ) && wb_master_ack_i && !wb_master_err_i;
    assign pop  = (count != '0) && sample_ready_i;

    // Occupancy the FIFO will have after this cycle's push (and possible pop).
    assign count_after_push = pop ? count : count + CNT_W'(1);

    // Transfer sequencer: address/length bookkeeping and registered bus/status outputs.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state     <= IDLE;
            adr_q     <= '0;
            remaining <= '0;
            busy_q    <= 1'b0;
            cyc_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        adr_q     <= base_adr_i;
                        remaining <= len_i;
                        err_q     <= 1'b0;
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state  <= READ;
                            busy_q <= 1'b1;
                            cyc_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (wb_master_err_i) begin
                        err_q <= 1'b1;
                        state <= DRAIN;
                        cyc_q <= 1'b0;
                    end else if (wb_master_ack_i) begin
                        adr_q     <= adr_q + AW'(4);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                            cyc_q <= 1'b0;
                        end else if (count_after_push == FULL_CNT) begin
                            state <= WAIT_SPACE;
                            cyc_q <= 1'b0;
                        end
                    end else if (wb_master_rty_i) begin
                        // Dropping the strobe for a cycle guarantees an idle gap before the retry.
                        state <= WAIT_SPACE;
                        cyc_q <= 1'b0;
                    end
                end
                WAIT_SPACE: begin
                    if (count < FULL_CNT) begin
                        state <= READ;
                        cyc_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; a flush on reset discards buffered samples.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sample storage; data is not reset, validity comes from the pointers.
    always_ff @(posedge wb_clk) begin
        if (push) mem[wr_ptr] <= wb_master_dat_i;
    end

    assign sample_o       = mem[rd_ptr];
    assign sample_valid_o = (count != '0);

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    assign wb_master_adr_o = adr_q;
    assign wb_master_cyc_o = cyc_q;
    assign wb_master_stb_o = cyc_q;
    assign wb_master_dat_o = '0;
    assign wb_master_sel_o = 4'hF;
    assign wb_master_we_o  = 1'b0;
    assign wb_master_cti_o = 3'b000;
    assign wb_master_bte_o = 2'b00;

endmodule
